// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the serial BCD sequencer front end:
//   state_t           sequencer state encoding
//   HDR_*_DEF         default command / response header bytes
//   RESULT_W          width of the ALU result {carry digit, 4 BCD digits}
//   FRAME_W           width of a serialised response {header, result}
//   PAYLOAD_BITS      command payload length: op + A[15:0] + B[15:0]
//   bcd_digits_valid  1 when every nibble of a 16-bit word is 0..9
// ----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [2:0] {
        S_HUNT,
        S_PAYLOAD,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_SEND
    } state_t;

    localparam logic [7:0] HDR_IN_DEF  = 8'h5A;
    localparam logic [7:0] HDR_OK_DEF  = 8'h96;
    localparam logic [7:0] HDR_ERR_DEF = 8'hE1;

    localparam int RESULT_W     = 20;
    localparam int FRAME_W      = 8 + RESULT_W;
    localparam int PAYLOAD_BITS = 33;

    function automatic logic bcd_digits_valid(input logic [15:0] value);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (value[i*4 +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_piso28.sv
// ----------------------------------------------------------------------------
// bcd_piso28
// Parallel-in / serial-out shifter for the 28-bit response frame.
// A load pulse captures the frame and raises valid; the frame then leaves
// MSB first, one bit per clock, and valid drops after exactly 28 bits.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   load_i         capture data_i and start shifting (wins over shifting)
//   data_i         frame to send, bit 27 first
//   dout_o         current serial bit (0 while idle)
//   valid_o        high while dout_o carries a frame bit
//   last_o         high during the final (28th) bit
// ----------------------------------------------------------------------------
module bcd_piso28
    import bcd_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] data_i,
    output logic               dout_o,
    output logic               valid_o,
    output logic               last_o
);

    logic [FRAME_W-1:0] shift_q;
    logic [4:0]         cnt_q;
    logic               valid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            shift_q <= data_i;
            cnt_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q) begin
            shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
            if (cnt_q == 5'(FRAME_W - 1)) begin
                cnt_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    assign dout_o  = shift_q[FRAME_W-1] & valid_q;
    assign valid_o = valid_q;
    assign last_o  = valid_q && (cnt_q == 5'(FRAME_W - 1));

endmodule

// File: rtl/bcd_serial_sequencer.sv
// ----------------------------------------------------------------------------
// bcd_serial_sequencer
// Front end for an external serial BCD add/subtract ALU. Hunts din for the
// command header, deserialises {op, A, B}, rejects non-BCD operands, runs one
// ALU operation over a start/done handshake with a timeout, and serialises
// {response header, 20-bit result} on dout.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   din_i          serial command bit, MSB first
//   dout_o         serial response bit, MSB first
//   dout_valid_o   high while dout_o carries a response bit
//   busy_o         high in every state except HUNT
//   frame_err_o    one-cycle pulse when an error response is chosen
//   alu_start_o    one-cycle ALU request
//   alu_op_o       0 = A+B, 1 = A-B
//   alu_a_o        operand A, 4 BCD digits
//   alu_b_o        operand B, 4 BCD digits
//   alu_done_i     one-cycle ALU completion strobe
//   alu_result_i   {carry/borrow digit, 4 BCD digits}, valid with alu_done_i
// ----------------------------------------------------------------------------
module bcd_serial_sequencer
    import bcd_pkg::*;
#(
    parameter logic [7:0] HDR_IN      = HDR_IN_DEF,
    parameter logic [7:0] HDR_OK      = HDR_OK_DEF,
    parameter logic [7:0] HDR_ERR     = HDR_ERR_DEF,
    parameter int         ALU_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                din_i,
    output logic                dout_o,
    output logic                dout_valid_o,
    output logic                busy_o,
    output logic                frame_err_o,
    output logic                alu_start_o,
    output logic                alu_op_o,
    output logic [15:0]         alu_a_o,
    output logic [15:0]         alu_b_o,
    input  logic                alu_done_i,
    input  logic [RESULT_W-1:0] alu_result_i
);

    localparam int TO_W = $clog2(ALU_TIMEOUT + 1);

    state_t                  state_q;
    logic [7:0]              window_q;
    logic [7:0]              window_d;
    logic [PAYLOAD_BITS-1:0] pay_q;
    logic [5:0]              pay_cnt_q;
    logic [TO_W-1:0]         to_cnt_q;
    logic                    alu_start_q;
    logic                    frame_err_q;
    logic                    alu_op_q;
    logic [15:0]             alu_a_q;
    logic [15:0]             alu_b_q;

    logic                    check_ok;
    logic                    wait_timeout;
    logic                    piso_load;
    logic [FRAME_W-1:0]      piso_data;
    logic                    piso_last;

    // The window is compared including the bit arriving this cycle, so the
    // first payload bit is the one right after the last header bit.
    assign window_d     = {window_q[6:0], din_i};
    assign check_ok     = bcd_digits_valid(pay_q[31:16]) && bcd_digits_valid(pay_q[15:0]);
    assign wait_timeout = (to_cnt_q == TO_W'(ALU_TIMEOUT - 1));

    // Response framing is chosen in the same cycle the decision is made, so
    // the first response bit appears on the cycle after CHECK or the done strobe.
    always_comb begin
        piso_load = 1'b0;
        piso_data = '0;
        case (state_q)
            S_CHECK: begin
                if (!check_ok) begin
                    piso_load = 1'b1;
                    piso_data = {HDR_ERR, {RESULT_W{1'b0}}};
                end
            end
            S_WAIT: begin
                if (alu_done_i) begin
                    piso_load = 1'b1;
                    piso_data = {HDR_OK, alu_result_i};
                end else if (wait_timeout) begin
                    piso_load = 1'b1;
                    piso_data = {HDR_ERR, {RESULT_W{1'b0}}};
                end
            end
            default: begin
                piso_load = 1'b0;
                piso_data = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_HUNT;
            window_q    <= '0;
            pay_q       <= '0;
            pay_cnt_q   <= '0;
            to_cnt_q    <= '0;
            alu_start_q <= 1'b0;
            frame_err_q <= 1'b0;
            alu_op_q    <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            alu_start_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_HUNT: begin
                    // Plain sliding window: a miss never realigns, so
                    // headers overlapping earlier bits still match.
                    window_q <= window_d;
                    if (window_d == HDR_IN) begin
                        pay_cnt_q <= '0;
                        state_q   <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    pay_q <= {pay_q[PAYLOAD_BITS-2:0], din_i};
                    if (pay_cnt_q == 6'(PAYLOAD_BITS - 1)) begin
                        state_q <= S_CHECK;
                    end else begin
                        pay_cnt_q <= pay_cnt_q + 6'd1;
                    end
                end
                S_CHECK: begin
                    if (check_ok) begin
                        alu_op_q    <= pay_q[32];
                        alu_a_q     <= pay_q[31:16];
                        alu_b_q     <= pay_q[15:0];
                        alu_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_SEND;
                    end
                end
                S_ISSUE: begin
                    // A done strobe coinciding with the request is not ours.
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done_i) begin
                        state_q <= S_SEND;
                    end else if (wait_timeout) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_SEND;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_SEND: begin
                    if (piso_last) begin
                        window_q <= '0;
                        state_q  <= S_HUNT;
                    end
                end
                default: begin
                    state_q <= S_HUNT;
                end
            endcase
        end
    end

    bcd_piso28 u_piso (
        .clock   (clock),
        .reset   (reset),
        .load_i  (piso_load),
        .data_i  (piso_data),
        .dout_o  (dout_o),
        .valid_o (dout_valid_o),
        .last_o  (piso_last)
    );

    assign busy_o      = (state_q != S_HUNT);
    assign frame_err_o = frame_err_q;
    assign alu_start_o = alu_start_q;
    assign alu_op_o    = alu_op_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;

endmodule
